// File: rtl/counter_pkg.sv
// Shared definitions for the wrap counter and its receive-side checker.
// Holds the checker state encoding, the default wrap point and the successor rule.
// Both ends import this so they agree on where the sequence wraps.
package counter_pkg;

  // Default last legal count before the sequence wraps back to 0.
  localparam logic [31:0] MAX_COUNT_DEFAULT = 32'h0000_0010;

  typedef enum logic [1:0] {
    HUNT    = 2'd0,
    ACQUIRE = 2'd1,
    LOCKED  = 2'd2
  } chk_state_t;

  // Next value in the wrapping sequence. Operates on 64 bits so that any
  // count width up to 64 can use it; callers cast to their own width.
  function automatic logic [63:0] succ(input logic [63:0] x, input logic [63:0] max_count);
    return (x == max_count) ? 64'd0 : x + 64'd1;
  endfunction

endpackage

// File: rtl/counter_checker_if.sv
// Sample stream into the checker plus the checker's status outputs.
// No latency of its own; pure signal bundle.
// No backpressure: the checker accepts a sample on every valid cycle.
interface counter_checker_if #(
  parameter int WIDTH     = 32,
  parameter int ERR_WIDTH = 16
);
  logic                 in_valid;
  logic [WIDTH-1:0]     in_count;
  logic                 clear;
  logic                 locked;
  logic                 error;
  logic [WIDTH-1:0]     expected;
  logic [WIDTH-1:0]     wrap_count;
  logic [ERR_WIDTH-1:0] error_count;

  // Source side: drives samples and clear, observes status.
  modport master (
    output in_valid, in_count, clear,
    input  locked, error, expected, wrap_count, error_count
  );

  // Checker side.
  modport slave (
    input  in_valid, in_count, clear,
    output locked, error, expected, wrap_count, error_count
  );
endinterface

// File: rtl/sat_counter.sv
// Saturating incrementer with synchronous clear; holds at all-ones.
// Latency: count visible one cycle after i_inc.
// Backpressure: none; clear wins over a same-cycle increment.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_inc,
  output logic [W-1:0] o_cnt
);

  logic [W-1:0] r_cnt;

  // Count up on i_inc until all-ones; clear drops the pending increment.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {W{1'b1}})) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/counter_checker.sv
// Locks onto a 0..MAX_COUNT wrapping stream and flags in-lock breaks, with wrap/error stats.
// Latency: every output is registered; a sample at edge N shows after edge N.
// Backpressure: none; samples are consumed on every in_valid cycle, gaps allowed.
module counter_checker
  import counter_pkg::*;
#(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] MAX_COUNT   = WIDTH'(MAX_COUNT_DEFAULT),
  parameter int               LOCK_CYCLES = 2,
  parameter int               ERR_WIDTH   = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  counter_checker_if.slave  mon
);

  // Run length is kept in 8 bits; LOCK_CYCLES is limited to 2..255.
  localparam logic [7:0] LOCK_RUN = 8'(LOCK_CYCLES);

  chk_state_t       r_state;
  logic [7:0]       r_run;
  logic [WIDTH-1:0] r_expected;
  logic             r_error;

  chk_state_t       w_state_nxt;
  logic [7:0]       w_run_nxt;
  logic [WIDTH-1:0] w_exp_nxt;
  logic             w_err_nxt;
  logic             w_wrap_inc;
  logic             w_err_inc;
  logic             w_legal;
  logic             w_match;
  logic [WIDTH-1:0] w_succ;

  assign w_legal = (mon.in_count <= MAX_COUNT);
  assign w_match = (mon.in_count == r_expected);
  assign w_succ  = WIDTH'(succ(64'(mon.in_count), 64'(MAX_COUNT)));

  // State, run length, expected value and error pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= HUNT;
      r_run      <= 8'd0;
      r_expected <= '0;
      r_error    <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_run      <= w_run_nxt;
      r_expected <= w_exp_nxt;
      r_error    <= w_err_nxt;
    end
  end

  // Next-state decode: everything holds unless a sample arrives.
  always_comb begin
    w_state_nxt = r_state;
    w_run_nxt   = r_run;
    w_exp_nxt   = r_expected;
    w_err_nxt   = 1'b0;
    w_wrap_inc  = 1'b0;
    w_err_inc   = 1'b0;
    if (mon.in_valid) begin
      case (r_state)
        HUNT: begin
          if (w_legal) begin
            w_state_nxt = ACQUIRE;
            w_run_nxt   = 8'd1;
            w_exp_nxt   = w_succ;
          end
        end
        ACQUIRE: begin
          if (w_match) begin
            w_exp_nxt = w_succ;
            w_run_nxt = r_run + 8'd1;
            if (r_run + 8'd1 == LOCK_RUN) begin
              w_state_nxt = LOCKED;
            end
          end else if (w_legal) begin
            w_run_nxt = 8'd1;
            w_exp_nxt = w_succ;
          end else begin
            w_state_nxt = HUNT;
            w_run_nxt   = 8'd0;
          end
        end
        LOCKED: begin
          if (w_match) begin
            w_exp_nxt  = w_succ;
            w_wrap_inc = (mon.in_count == MAX_COUNT);
          end else begin
            w_err_nxt = 1'b1;
            w_err_inc = 1'b1;
            if (w_legal) begin
              w_state_nxt = ACQUIRE;
              w_run_nxt   = 8'd1;
              w_exp_nxt   = w_succ;
            end else begin
              w_state_nxt = HUNT;
              w_run_nxt   = 8'd0;
            end
          end
        end
        default: begin
          w_state_nxt = HUNT;
          w_run_nxt   = 8'd0;
        end
      endcase
    end
  end

  sat_counter #(.W(WIDTH)) u_wrap_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (mon.clear),
    .i_inc (w_wrap_inc),
    .o_cnt (mon.wrap_count)
  );

  sat_counter #(.W(ERR_WIDTH)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (mon.clear),
    .i_inc (w_err_inc),
    .o_cnt (mon.error_count)
  );

  assign mon.locked   = (r_state == LOCKED);
  assign mon.error    = r_error;
  assign mon.expected = r_expected;

endmodule
